// File: rtl/vga_sync_recover.sv
// -----------------------------------------------------------------------------
// vga_sync_recover
//
// Recovers pixel/line counters and a lock indication from an asynchronous
// VGA HS/VS pair sampled on the pixel clock. Each sync input is synchronized,
// edge-detected and measured. A small FSM declares lock after LOCK_FRAMES
// consecutive frames whose line and frame lengths match HPERIOD/VPERIOD.
//
// Ports
//   PCK          in   pixel clock, all logic on the rising edge
//   RST          in   synchronous reset, active-high
//   VGA_HS       in   horizontal sync (async to PCK, active-low by default)
//   VGA_VS       in   vertical sync (async to PCK, active-low by default)
//   HCNT[9:0]    out  regenerated pixel count within the line
//   VCNT[9:0]    out  regenerated line count within the frame
//   HMEAS[9:0]   out  last measured line length in PCK cycles (sat. 1023)
//   VMEAS[9:0]   out  last measured frame length in lines (sat. 1023)
//   LOCKED       out  high while the input timing matches HPERIOD/VPERIOD
//   FRAME_START  out  one-cycle pulse the cycle after each VS active edge
//
// Build option
//   VGA_SYNC_RECOVER_POL_AUTO_EN  when defined, the polarity of each sync
//   input is learned from its high/low times and edges are taken on the
//   active-going transition; a learned polarity change forces UNLOCKED.
//   When undefined both inputs are strictly active-low.
//
// Lock FSM
//   state      | meaning
//   UNLOCKED   | no valid timing; waits for a VS edge to start checking
//   CHECK      | counting consecutive good frames towards LOCK_FRAMES
//   LOCKED     | timing matches; any bad line or frame drops lock
// -----------------------------------------------------------------------------
module vga_sync_recover #(
  parameter int HPERIOD     = 800,
  parameter int VPERIOD     = 525,
  parameter int HLOAD       = 19,
  parameter int VLOAD       = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic [9:0] HMEAS,
  output logic [9:0] VMEAS,
  output logic       LOCKED,
  output logic       FRAME_START
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_CHECK    = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  localparam logic [9:0] HPER_V  = 10'(HPERIOD);
  localparam logic [9:0] HPER_M1 = 10'(HPERIOD - 1);
  localparam logic [9:0] VPER_V  = 10'(VPERIOD);
  localparam logic [9:0] VPER_M1 = 10'(VPERIOD - 1);
  localparam logic [9:0] HLOAD_V = 10'(HLOAD);
  localparam logic [9:0] VLOAD_V = 10'(VLOAD);
  localparam logic [9:0] SAT_V   = 10'h3FF;
  localparam logic [3:0] LF_V    = 4'(LOCK_FRAMES);

  // synchronizers and previous-value registers
  logic r_hs_s1, r_hs_s2, r_hs_prev;
  logic r_vs_s1, r_vs_s2, r_vs_prev;

  always_ff @(posedge PCK) begin
    if (RST) begin
      r_hs_s1   <= 1'b1;
      r_hs_s2   <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_s1   <= VGA_HS;
      r_hs_s2   <= r_hs_s1;
      r_hs_prev <= r_hs_s2;
      r_vs_s1   <= VGA_VS;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
    end
  end

  logic w_hs_fall;
  logic w_vs_fall;
  logic w_pol_chg;

`ifdef VGA_SYNC_RECOVER_POL_AUTO_EN
  // Phase timers are wide enough for a full VS phase counted in pixels.
  localparam int TW = 20;
  localparam logic [TW-1:0] TSAT = {TW{1'b1}};

  logic [TW-1:0] r_hs_run, r_hs_hi, r_hs_lo;
  logic [TW-1:0] r_vs_run, r_vs_hi, r_vs_lo;
  logic          r_hs_pol_low, r_vs_pol_low;
  logic [TW-1:0] w_hs_hi_nxt, w_hs_lo_nxt, w_vs_hi_nxt, w_vs_lo_nxt;
  logic          w_hs_tog, w_vs_tog;
  logic          w_hs_pol_nxt, w_vs_pol_nxt;

  assign w_hs_tog = r_hs_s2 ^ r_hs_prev;
  assign w_vs_tog = r_vs_s2 ^ r_vs_prev;

  // On a toggle the phase that just ended is latched as its high or low time.
  always_comb begin
    w_hs_hi_nxt = r_hs_hi;
    w_hs_lo_nxt = r_hs_lo;
    w_vs_hi_nxt = r_vs_hi;
    w_vs_lo_nxt = r_vs_lo;
    if (w_hs_tog) begin
      if (r_hs_prev) w_hs_hi_nxt = r_hs_run;
      else           w_hs_lo_nxt = r_hs_run;
    end
    if (w_vs_tog) begin
      if (r_vs_prev) w_vs_hi_nxt = r_vs_run;
      else           w_vs_lo_nxt = r_vs_run;
    end
  end

  // Shorter phase is the active pulse.
  assign w_hs_pol_nxt = (w_hs_lo_nxt < w_hs_hi_nxt);
  assign w_vs_pol_nxt = (w_vs_lo_nxt < w_vs_hi_nxt);

  always_ff @(posedge PCK) begin
    if (RST) begin
      // hi=1/lo=0 makes the power-up guess active-low
      r_hs_run     <= '0;
      r_hs_hi      <= TW'(1);
      r_hs_lo      <= '0;
      r_hs_pol_low <= 1'b1;
      r_vs_run     <= '0;
      r_vs_hi      <= TW'(1);
      r_vs_lo      <= '0;
      r_vs_pol_low <= 1'b1;
    end else begin
      r_hs_hi      <= w_hs_hi_nxt;
      r_hs_lo      <= w_hs_lo_nxt;
      r_hs_pol_low <= w_hs_pol_nxt;
      r_vs_hi      <= w_vs_hi_nxt;
      r_vs_lo      <= w_vs_lo_nxt;
      r_vs_pol_low <= w_vs_pol_nxt;
      if (w_hs_tog)              r_hs_run <= TW'(1);
      else if (r_hs_run != TSAT) r_hs_run <= r_hs_run + TW'(1);
      if (w_vs_tog)              r_vs_run <= TW'(1);
      else if (r_vs_run != TSAT) r_vs_run <= r_vs_run + TW'(1);
    end
  end

  assign w_hs_fall = r_hs_pol_low ? (r_hs_prev & ~r_hs_s2) : (~r_hs_prev & r_hs_s2);
  assign w_vs_fall = r_vs_pol_low ? (r_vs_prev & ~r_vs_s2) : (~r_vs_prev & r_vs_s2);
  assign w_pol_chg = (w_hs_pol_nxt != r_hs_pol_low) || (w_vs_pol_nxt != r_vs_pol_low);
`else
  assign w_hs_fall = r_hs_prev & ~r_hs_s2;
  assign w_vs_fall = r_vs_prev & ~r_vs_s2;
  assign w_pol_chg = 1'b0;
`endif

  // regenerated counters
  logic [9:0] r_hcnt, r_vcnt;
  logic       w_hwrap;

  assign w_hwrap = (r_hcnt == HPER_M1);

  always_ff @(posedge PCK) begin
    if (RST) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      if (w_hs_fall)    r_hcnt <= HLOAD_V;
      else if (w_hwrap) r_hcnt <= '0;
      else              r_hcnt <= r_hcnt + 10'd1;

      if (w_vs_fall)
        r_vcnt <= VLOAD_V;
      else if (w_hwrap && !w_hs_fall)
        r_vcnt <= (r_vcnt == VPER_M1) ? 10'd0 : r_vcnt + 10'd1;
    end
  end

  // line / frame measurement
  logic [9:0] r_hlen, r_vlen, r_hmeas, r_vmeas;

  always_ff @(posedge PCK) begin
    if (RST) begin
      r_hlen  <= '0;
      r_vlen  <= '0;
      r_hmeas <= '0;
      r_vmeas <= '0;
    end else begin
      if (w_hs_fall) begin
        r_hlen  <= 10'd1;
        r_hmeas <= r_hlen;
      end else if (r_hlen != SAT_V) begin
        r_hlen <= r_hlen + 10'd1;
      end

      if (w_vs_fall) begin
        r_vlen  <= 10'd1;
        r_vmeas <= r_vlen;
      end else if (w_hs_fall && (r_vlen != SAT_V)) begin
        r_vlen <= r_vlen + 10'd1;
      end
    end
  end

  // good/bad classification
  logic w_line_bad, w_vs_misalign, w_frame_end_bad, w_frame_good, w_bad;
  logic r_frame_bad;

  // A saturated hlen means sync is lost, even before the next HS edge.
  assign w_line_bad = (w_hs_fall && (r_hlen != HPER_V)) || (r_hlen == SAT_V);

  // VS edges always coincide with an HS edge in valid timing; a lone VS edge
  // (e.g. edges taken on the wrong polarity) marks the frame bad.
  assign w_vs_misalign = w_vs_fall && !w_hs_fall;

  // The line ending at the VS edge belongs to the frame that ends there.
  assign w_frame_end_bad = w_vs_fall &&
                           ((r_vlen != VPER_V) || r_frame_bad || w_line_bad || w_vs_misalign);
  assign w_frame_good    = w_vs_fall && !w_frame_end_bad;
  assign w_bad           = w_line_bad || w_frame_end_bad || (r_vlen == SAT_V) || w_pol_chg;

  always_ff @(posedge PCK) begin
    if (RST)             r_frame_bad <= 1'b0;
    else if (w_vs_fall)  r_frame_bad <= 1'b0;
    else if (w_line_bad) r_frame_bad <= 1'b1;
  end

  // lock FSM
  logic [1:0] r_state, w_state_nxt;
  logic [3:0] r_frames, w_frames_nxt;
  logic       r_locked, r_frame_start;

  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames;
    case (r_state)
      S_UNLOCKED: begin
        // the partial frame that ends here is never scored
        w_frames_nxt = 4'd0;
        if (w_vs_fall && !w_pol_chg) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_bad) begin
          w_state_nxt  = S_UNLOCKED;
          w_frames_nxt = 4'd0;
        end else if (w_frame_good) begin
          w_frames_nxt = r_frames + 4'd1;
          if ((r_frames + 4'd1) == LF_V) w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_bad) begin
          w_state_nxt  = S_UNLOCKED;
          w_frames_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt  = S_UNLOCKED;
        w_frames_nxt = 4'd0;
      end
    endcase
  end

  // LOCKED is registered from the next state so it drops one cycle after
  // the offending edge, in step with the state register.
  always_ff @(posedge PCK) begin
    if (RST) begin
      r_state       <= S_UNLOCKED;
      r_frames      <= '0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frames      <= w_frames_nxt;
      r_locked      <= (w_state_nxt == S_LOCKED);
      r_frame_start <= w_vs_fall;
    end
  end

  assign HCNT        = r_hcnt;
  assign VCNT        = r_vcnt;
  assign HMEAS       = r_hmeas;
  assign VMEAS       = r_vmeas;
  assign LOCKED      = r_locked;
  assign FRAME_START = r_frame_start;

endmodule

// File: doc/vga_sync_recover.md
VGA_SYNC_RECOVER -- requirements
Module: vga_sync_recover

Interface
REQ-001 Parameter HPERIOD, default 800: expected PCK cycles per line.
REQ-002 Parameter VPERIOD, default 525: expected lines per frame.
REQ-003 Parameter HLOAD, default 19: value loaded into HCNT on detected HS falling edge (HFRONT 16 + 3-cycle input latency).
REQ-004 Parameter VLOAD, default 10: value loaded into VCNT on detected VS falling edge.
REQ-005 Parameter LOCK_FRAMES, default 2, range 1..15: consecutive good frames required for lock.
REQ-006 PCK  input  1  pixel clock; all logic on rising edge.
REQ-007 RST  input  1  reset, synchronous, active-high.
REQ-008 VGA_HS  input  1  horizontal sync, asynchronous to PCK, active-low.
REQ-009 VGA_VS  input  1  vertical sync, asynchronous to PCK, active-low; falling edge coincides with an HS falling edge.
REQ-010 HCNT  output  10  regenerated horizontal pixel count.
REQ-011 VCNT  output  10  regenerated line count.
REQ-012 HMEAS  output  10  last measured line length in PCK cycles, saturating at 1023.
REQ-013 VMEAS  output  10  last measured frame length in lines, saturating at 1023.
REQ-014 LOCKED  output  1  high while input timing matches HPERIOD/VPERIOD.
REQ-015 FRAME_START  output  1  one-cycle pulse on each detected VS falling edge.

Function
REQ-016 HS and VS each pass through a 2-FF synchronizer followed by a previous-value register; a falling edge (hs_fall/vs_fall) is asserted when the previous value is 1 and the synchronized value is 0.
REQ-017 HCNT: on hs_fall, load HLOAD; otherwise load 0 at HPERIOD-1, else increment.
REQ-018 VCNT: on vs_fall (always coincident with hs_fall), load VLOAD; otherwise increment on HCNT wrap, with wrap from VPERIOD-1 to 0.
REQ-019 Line counter hlen: reset to 1 on hs_fall, else increment, saturating at 1023; on hs_fall, HMEAS is loaded with hlen.
REQ-020 Frame counter vlen: reset to 1 on vs_fall, else increment on hs_fall, saturating at 1023; on vs_fall, VMEAS is loaded with vlen.
REQ-021 A line is bad when HMEAS != HPERIOD at hs_fall, or when hlen reaches 1023 (sync lost); a frame is bad when VMEAS != VPERIOD at vs_fall, when vlen reaches 1023, or when it contained any bad line.
REQ-022 Lock FSM states and transitions:
- UNLOCKED: enter CHECK on vs_fall; frame counter = 0.
- CHECK: on each good frame, increment frame counter and enter LOCKED when the count reaches LOCK_FRAMES; on a bad line or bad frame, return to UNLOCKED.
- LOCKED: on a bad line or bad frame, return to UNLOCKED.
REQ-023 The first partial frame after leaving UNLOCKED is discarded and never counts as good.
REQ-024 LOCKED is a registered output equal to (state == LOCKED); it deasserts on the cycle after the bad event is detected.
REQ-025 FRAME_START is asserted on the cycle after vs_fall, in all FSM states.
REQ-026 Counters free-run regardless of lock state; HCNT/VCNT are only meaningful when LOCKED=1.
REQ-027 An hs_fall that occurs while hlen is saturated counts as a bad line; it still loads HMEAS=1023 and HCNT=HLOAD.

Reset
REQ-028 On RST=1: HCNT=0, VCNT=0, HMEAS=0, VMEAS=0, LOCKED=0, FRAME_START=0, FSM=UNLOCKED, synchronizers and previous-value registers=1, hlen=vlen=0.
REQ-029 RST asserted mid-frame or while LOCKED takes effect at the next PCK edge; lock must be reacquired from scratch.

Configuration
REQ-030 Macro VGA_SYNC_RECOVER_POL_AUTO_EN:
- When defined: per input, track the high-time and low-time of each HS period, and likewise per VS period; polarity is taken as active-low if low-time < high-time, else active-high; edges are detected on the active-going transition; a polarity change forces UNLOCKED.
- When undefined: inputs are strictly active-low and no polarity logic exists.

Verification
REQ-031 Drive standard 640x480 timing (800x525, HS low at HCNT 16..111, VS low at lines 10..11) for 4 frames -> LOCKED=1 within 1 cycle after the 3rd vs_fall; HMEAS=800, VMEAS=525; HCNT tracks source HCNT +/- 0.
REQ-032 After lock, shorten one line to 799 cycles -> LOCKED=0 at that hs_fall+1; relock after 2 further good frames.
REQ-033 Hold HS high after lock -> hlen saturates at 1023, LOCKED=0, HMEAS=1023 on the next hs_fall.
REQ-034 Assert RST for 1 cycle while locked at mid-line -> all outputs 0 next cycle; LOCKED returns only after the full reacquisition sequence.
REQ-035 Frame of 524 lines -> VMEAS=524, LOCKED=0, FRAME_START pulse still emitted.
REQ-036 With VGA_SYNC_RECOVER_POL_AUTO_EN, drive inverted (active-high) sync -> LOCKED=1 after polarity settles plus 2 good frames; without the macro, the same stimulus never produces LOCKED=1.
